// File: rtl/rom_download_sequencer_if.sv
// HPS download bus plus the byte-wide ROM write port of the sequencer.
// slave  : the sequencer (consumes ioctl_*, drives ioctl_wait and rom_*)
// master : the HPS/core side
interface rom_download_sequencer_if #(
  parameter int ROM_AW = 16
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [26:0]       ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wait;
  logic [3:0]        rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, rom_we, rom_addr, rom_data
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/rom_download_sequencer.sv
// ROM download sequencer: splits 16-bit HPS download words into two byte
// writes, decodes them into four ROM regions, throttles the HPS with
// ioctl_wait and holds the core in reset until RST_HOLD cycles after the
// download ends.
// Optional feature macro: ROM_DOWNLOAD_CHECKSUM_EN adds csum[15:0], the
// mod-2^16 sum of every in-range byte written since download rose.
module rom_download_sequencer #(
  parameter int ROM_AW   = 16,
  parameter int R0_END   = 'h10000,
  parameter int R1_END   = 'h18000,
  parameter int R2_END   = 'h20000,
  parameter int R3_END   = 'h28000,
  parameter int RST_HOLD = 1024
) (
  input  logic clk_sys,
  input  logic reset,
  rom_download_sequencer_if.slave bus,
  output logic core_reset,
  output logic loaded,
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  output logic [15:0] csum,
`endif
  output logic err
);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, HOLD, RUN} state_t;

  state_t            state_q, state_d;
  logic [26:0]       addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              wait_q, wait_d;
  logic [3:0]        we_q, we_d;
  logic [ROM_AW-1:0] raddr_q, raddr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              crst_q, crst_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              dl_pend_q, dl_pend_d;  // a download happened, hold not yet started
  logic [HW-1:0]     hold_q, hold_d;

  logic [26:0]       byte_addr, base;
  logic [3:0]        dec_we;

  // Region decode of the byte currently being issued (low byte in WR_LO, high in WR_HI)
  always_comb begin
    byte_addr = addr_q + {26'd0, state_q == WR_HI};
    base      = '0;
    dec_we    = '0;
    if (byte_addr < 27'(R0_END)) begin
      dec_we = 4'b0001;
    end else if (byte_addr < 27'(R1_END)) begin
      dec_we = 4'b0010; base = 27'(R0_END);
    end else if (byte_addr < 27'(R2_END)) begin
      dec_we = 4'b0100; base = 27'(R1_END);
    end else if (byte_addr < 27'(R3_END)) begin
      dec_we = 4'b1000; base = 27'(R2_END);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    wait_d    = wait_q;
    we_d      = '0;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    hold_d    = hold_q;
    dl_pend_d = dl_pend_q | bus.ioctl_download;
    err_d     = err_q | (bus.ioctl_wr & bus.ioctl_download &
                         (wait_q | state_q == WR_LO | state_q == WR_HI));
    case (state_q)
      IDLE, HOLD, RUN: begin
        if (bus.ioctl_download) begin
          // a fresh download aborts hold/run and is served like idle
          state_d = IDLE;
          if (bus.ioctl_wr) begin
            addr_d  = bus.ioctl_addr;
            dout_d  = bus.ioctl_dout;
            wait_d  = 1'b1;
            state_d = WR_LO;
          end
        end else if (state_q == IDLE && dl_pend_q) begin
          state_d   = HOLD;
          hold_d    = HW'(RST_HOLD - 1);
          dl_pend_d = 1'b0;
        end else if (state_q == HOLD) begin
          if (hold_q == '0) state_d = RUN;
          else              hold_d  = hold_q - 1'b1;
        end
      end
      WR_LO: begin
        we_d    = dec_we;
        raddr_d = ROM_AW'(byte_addr - base);
        rdata_d = dout_q[7:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        we_d    = dec_we;
        raddr_d = ROM_AW'(byte_addr - base);
        rdata_d = dout_q[15:8];
        wait_d  = 1'b0;
        // going straight to HOLD keeps the hold measured from the last byte
        if (!bus.ioctl_download && dl_pend_q) begin
          state_d   = HOLD;
          hold_d    = HW'(RST_HOLD - 1);
          dl_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    crst_d   = (state_d != RUN);
    loaded_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      dout_q    <= '0;
      wait_q    <= 1'b0;
      we_q      <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      crst_q    <= 1'b1;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
      dl_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      crst_q    <= crst_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      dl_pend_q <= dl_pend_d;
      hold_q    <= hold_d;
    end
  end

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  logic        dl_prev_q, dl_prev_d;
  logic [15:0] csum_q, csum_d;

  // Running byte sum, restarted on each download rising edge
  always_comb begin
    dl_prev_d = bus.ioctl_download;
    csum_d    = csum_q;
    if (bus.ioctl_download && !dl_prev_q) csum_d = '0;
    else if (we_d != '0)                  csum_d = csum_q + {8'd0, rdata_d};
  end

  // Checksum registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev_q <= 1'b0;
      csum_q    <= '0;
    end else begin
      dl_prev_q <= dl_prev_d;
      csum_q    <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

  assign bus.ioctl_wait = wait_q;
  assign bus.rom_we     = we_q;
  assign bus.rom_addr   = raddr_q;
  assign bus.rom_data   = rdata_q;
  assign core_reset     = crst_q | bus.ioctl_download;
  assign loaded         = loaded_q;
  assign err            = err_q;
endmodule

// File: tb/tb_rom_download_sequencer.sv
// Directed bench for rom_download_sequencer (RST_HOLD=4).
module tb_rom_download_sequencer;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic core_reset, loaded, err;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  logic [15:0] csum;
`endif
  int total = 0, passed = 0, failed = 0;

  rom_download_sequencer_if #(.ROM_AW(16)) bus ();

  rom_download_sequencer #(.ROM_AW(16), .RST_HOLD(4)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .loaded     (loaded),
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    .csum       (csum),
`endif
    .err        (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word: strobe, then expect wait for two cycles and the two byte writes.
  task automatic send_word(input logic [26:0] a, input logic [15:0] d,
                           input logic [3:0] we0, input logic [15:0] la0,
                           input logic [3:0] we1, input logic [15:0] la1,
                           input bit drop);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    if (drop) bus.ioctl_download = 1'b0;
    chk("wait_1", 32'(bus.ioctl_wait), 32'd1);
    tick;
    chk("lo_we",   32'(bus.rom_we),   32'(we0));
    if (we0 != 4'd0) begin
      chk("lo_addr", 32'(bus.rom_addr), 32'(la0));
      chk("lo_data", 32'(bus.rom_data), 32'(d[7:0]));
    end
    chk("wait_2", 32'(bus.ioctl_wait), 32'd1);
    tick;
    chk("hi_we",   32'(bus.rom_we),   32'(we1));
    if (we1 != 4'd0) begin
      chk("hi_addr", 32'(bus.rom_addr), 32'(la1));
      chk("hi_data", 32'(bus.rom_data), 32'(d[15:8]));
    end
    chk("wait_off", 32'(bus.ioctl_wait), 32'd0);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    tick; tick;
    chk("rst_we",     32'(bus.rom_we),     32'd0);
    chk("rst_addr",   32'(bus.rom_addr),   32'd0);
    chk("rst_data",   32'(bus.rom_data),   32'd0);
    chk("rst_wait",   32'(bus.ioctl_wait), 32'd0);
    chk("rst_corerst",32'(core_reset),     32'd1);
    chk("rst_loaded", 32'(loaded),         32'd0);
    chk("rst_err",    32'(err),            32'd0);
    reset = 1'b0;

    // no download ever: core stays in reset
    repeat (8) tick;
    chk("nodl_corerst", 32'(core_reset), 32'd1);
    chk("nodl_loaded",  32'(loaded),     32'd0);

    bus.ioctl_download = 1'b1;
    tick;
    send_word(27'h0,       16'hBEEF, 4'b0001, 16'h0000, 4'b0001, 16'h0001, 1'b0);
    send_word(27'h0FFFE,   16'h1234, 4'b0001, 16'hFFFE, 4'b0001, 16'hFFFF, 1'b0);
    send_word(27'h10000,   16'h5678, 4'b0010, 16'h0000, 4'b0010, 16'h0001, 1'b0);
    send_word(27'h18000,   16'h9ABC, 4'b0100, 16'h0000, 4'b0100, 16'h0001, 1'b0);
    send_word(27'h27FFE,   16'hDEF0, 4'b1000, 16'h7FFE, 4'b1000, 16'h7FFF, 1'b0);
    send_word(27'h28000,   16'h1111, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 1'b0);
    chk("oor_err", 32'(err), 32'd0);

    // back-to-back strobes: second is dropped and flagged
    bus.ioctl_addr = 27'h2;
    bus.ioctl_dout = 16'hA55A;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_addr = 27'h40;
    bus.ioctl_dout = 16'h7777;
    tick;
    bus.ioctl_wr = 1'b0;
    chk("b2b_lo_addr", 32'(bus.rom_addr), 32'h2);
    chk("b2b_lo_data", 32'(bus.rom_data), 32'h5A);
    chk("b2b_err",     32'(err),          32'd1);
    tick;
    chk("b2b_hi_addr", 32'(bus.rom_addr), 32'h3);
    chk("b2b_hi_data", 32'(bus.rom_data), 32'hA5);
    tick;
    chk("b2b_no2nd",   32'(bus.rom_we),   32'd0);
    tick;
    chk("b2b_no2nd_b", 32'(bus.rom_we),   32'd0);

    // last word with download falling; hold of 4 cycles after last byte
    send_word(27'h4, 16'h0102, 4'b0001, 16'h0004, 4'b0001, 16'h0005, 1'b1);
    chk("hold0_corerst", 32'(core_reset), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("hold_corerst", 32'(core_reset), 32'd1);
      chk("hold_loaded",  32'(loaded),     32'd0);
    end
    tick;
    chk("run_corerst", 32'(core_reset), 32'd0);
    chk("run_loaded",  32'(loaded),     32'd1);

    // strobe without download: ignored
    bus.ioctl_wr = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    tick;
    chk("nodl_wr_we",     32'(bus.rom_we), 32'd0);
    tick;
    chk("nodl_wr_we2",    32'(bus.rom_we), 32'd0);
    chk("nodl_wr_loaded", 32'(loaded),     32'd1);

    // download rises in RUN
    bus.ioctl_download = 1'b1;
    #1;
    chk("rise_corerst", 32'(core_reset), 32'd1);
    tick;
    chk("rise_loaded",  32'(loaded),     32'd0);

    // async reset in WR_LO: high byte never issued
    bus.ioctl_addr = 27'h6;
    bus.ioctl_dout = 16'hCAFE;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_we",      32'(bus.rom_we),     32'd0);
    chk("arst_wait",    32'(bus.ioctl_wait), 32'd0);
    chk("arst_err",     32'(err),            32'd0);
    chk("arst_corerst", 32'(core_reset),     32'd1);
    tick;
    reset = 1'b0;
    tick;
    chk("arst_nohi",    32'(bus.rom_we),     32'd0);
    tick;
    chk("arst_nohi2",   32'(bus.rom_we),     32'd0);

    send_word(27'h0, 16'h0201, 4'b0001, 16'h0000, 4'b0001, 16'h0001, 1'b0);
    send_word(27'h2, 16'h00FF, 4'b0001, 16'h0002, 4'b0001, 16'h0003, 1'b0);
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    chk("csum", 32'(csum), 32'h0102);
`endif
    chk("post_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
